// File: rtl/perif_hs_pkg.sv
// Shared types and width helpers for the Perif send/ack initiator.
package perif_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    REL  = 2'b10
  } state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 16;

  // Read/write pointer width for a power-of-two FIFO.
  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width; must represent 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Timeout counter width; counts 0..timeout-1.
  function automatic int tmo_w(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/perif_initiator_if.sv
// Local-write and send/ack handshake signals of the Perif initiator.
interface perif_initiator_if
  import perif_hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              send;
  logic [DATA_W-1:0] data_out;
  logic              ack;
  logic              busy;
  logic              done;
  logic              timeout_err;

  // Initiator side: accepts words, drives the request, receives ack.
  modport master (
    input  wr_data, wr_valid, ack,
    output wr_ready, send, data_out, busy, done, timeout_err
  );

  // Environment side: local writer plus responder.
  modport slave (
    output wr_data, wr_valid, ack,
    input  wr_ready, send, data_out, busy, done, timeout_err
  );
endinterface

// File: rtl/perif_hs_fifo.sv
// Small synchronous FIFO buffering outgoing words; head is always visible.
module perif_hs_fifo
  import perif_hs_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              wr_ready
);
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int OW = occ_w(FIFO_DEPTH);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     occ;
  logic [OW-1:0]     occ_next;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    occ_next = occ;
    if (push_ok && !pop_ok) begin
      occ_next = occ + OW'(1);
    end else if (!push_ok && pop_ok) begin
      occ_next = occ - OW'(1);
    end
  end

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered not-full flag; reset flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      wr_ready <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      occ      <= occ_next;
      wr_ready <= (occ_next != OCC_FULL);
    end
  end

endmodule

// File: rtl/perif_initiator.sv
// Initiator end of the Perif four-phase send/ack handshake with word FIFO
// and per-word timeout.
module perif_initiator
  import perif_hs_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  perif_initiator_if.master bus
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_REL  = REL;

  localparam int CW = tmo_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              send_r;
  logic [DATA_W-1:0] dout_r;
  logic              done_r;
  logic              terr_r;

  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rdy;
  logic              push;
  logic              pop;
  logic              req_ack;
  logic              req_tmo;
  logic              load;

  // Word buffer between local logic and the handshake engine.
  perif_hs_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.wr_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .wr_ready  (fifo_rdy)
  );

  // A push is taken only against the registered ready flag.
  assign push = bus.wr_valid & fifo_rdy;

  // The head leaves the FIFO only when the request phase ends (ack or timeout).
  assign req_ack = (state == ST_REQ) & bus.ack;
  assign req_tmo = (state == ST_REQ) & ~bus.ack & (cnt == CNT_LAST);
  assign pop     = req_ack | req_tmo;

  // New request starts from IDLE or REL once the responder has released ack.
  assign load = ~fifo_empty & ~bus.ack & ((state == ST_IDLE) | (state == ST_REL));

  assign bus.wr_ready    = fifo_rdy;
  assign bus.send        = send_r;
  assign bus.data_out    = dout_r;
  assign bus.done        = done_r;
  assign bus.timeout_err = terr_r;
  assign bus.busy        = ~fifo_empty | (state != ST_IDLE);

  // Handshake FSM, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      send_r <= 1'b0;
      dout_r <= '0;
      done_r <= 1'b0;
      terr_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      terr_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            state  <= ST_REQ;
            send_r <= 1'b1;
            dout_r <= head;
            cnt    <= '0;
          end
        end
        ST_REQ: begin
          if (req_ack) begin
            state  <= ST_REL;
            send_r <= 1'b0;
            done_r <= 1'b1;
          end else if (req_tmo) begin
            state  <= ST_REL;
            send_r <= 1'b0;
            terr_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_REL: begin
          // Wait for ack low; no timeout while the responder lingers here.
          if (!bus.ack) begin
            if (load) begin
              state  <= ST_REQ;
              send_r <= 1'b1;
              dout_r <= head;
              cnt    <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          send_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perif_initiator.sv
// Directed bench for perif_initiator: table-driven single-word transfer plus
// hand-written multi-cycle sequences (burst, timeout, stale ack, reset, long ack).
module tb_perif_initiator;
  localparam int R_NORMAL = 0;
  localparam int R_SILENT = 1;
  localparam int R_FORCE  = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   rmode;
  logic rforce;
  logic rs1;

  perif_initiator_if #(.DATA_W(8)) bus ();

  perif_initiator #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .TIMEOUT    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder model: in normal mode ack rises 2 cycles after send rises and
  // falls 1 cycle after send falls; it can also stay silent or be forced.
  always @(posedge clk) begin
    if (rst) begin
      rs1     <= 1'b0;
      bus.ack <= 1'b0;
    end else begin
      rs1 <= bus.send;
      case (rmode)
        R_NORMAL: bus.ack <= bus.send & rs1;
        R_SILENT: bus.ack <= 1'b0;
        default:  bus.ack <= rforce;
      endcase
    end
  end

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       e_send;
    logic [7:0] e_dout;
    logic       e_rdy;
    logic       e_busy;
    logic       e_done;
    logic       e_terr;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) begin
      check("done_terr_exclusive", {31'd0, bus.done & bus.timeout_err}, 32'd0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy || bus.ack) && n < 60) begin
      step();
      n++;
    end
    check(name, {31'd0, bus.busy | bus.ack}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       got;
    logic [7:0] dv;
    int         dn_cyc [$];
    logic [7:0] dn_dat [$];
    int         exp_cyc [4];
    logic [7:0] exp_dat [4];
    logic       es;
    logic [7:0] ed;

    errors       = 0;
    checks       = 0;
    rmode        = R_NORMAL;
    rforce       = 1'b0;
    rst          = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;

    // Single-word transfer, cycle by cycle after the push edge.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};

    step();
    step();
    step();
    rst = 1'b0;

    // Reset values
    check("rst_send",     {31'd0, bus.send},        32'd0);
    check("rst_data_out", {24'd0, bus.data_out},    32'd0);
    check("rst_done",     {31'd0, bus.done},        32'd0);
    check("rst_terr",     {31'd0, bus.timeout_err}, 32'd0);
    check("rst_wr_ready", {31'd0, bus.wr_ready},    32'd1);
    check("rst_busy",     {31'd0, bus.busy},        32'd0);

    // 1. single word 0xA5
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = tbl[i].wv;
      bus.wr_data  = tbl[i].wd;
      step();
      check($sformatf("t1_send_%0d", i), {31'd0, bus.send},        {31'd0, tbl[i].e_send});
      check($sformatf("t1_dout_%0d", i), {24'd0, bus.data_out},    {24'd0, tbl[i].e_dout});
      check($sformatf("t1_rdy_%0d", i),  {31'd0, bus.wr_ready},    {31'd0, tbl[i].e_rdy});
      check($sformatf("t1_busy_%0d", i), {31'd0, bus.busy},        {31'd0, tbl[i].e_busy});
      check($sformatf("t1_done_%0d", i), {31'd0, bus.done},        {31'd0, tbl[i].e_done});
      check($sformatf("t1_terr_%0d", i), {31'd0, bus.timeout_err}, {31'd0, tbl[i].e_terr});
    end
    bus.wr_valid = 1'b0;
    wait_idle("t1_idle");

    // 2. five back-to-back pushes into a 4-deep FIFO; the fifth is refused
    exp_cyc = '{4, 9, 14, 19};
    exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 30; k++) begin
      if (k < 5) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'((k + 1) * 17);
      end else begin
        bus.wr_valid = 1'b0;
      end
      step();
      if (k == 3) check("t2_wr_ready_full", {31'd0, bus.wr_ready}, 32'd0);
      if (k == 4) check("t2_wr_ready_pop",  {31'd0, bus.wr_ready}, 32'd1);
      if (bus.done) begin
        dn_cyc.push_back(k);
        dn_dat.push_back(bus.data_out);
      end
    end
    check("t2_done_count", dn_cyc.size(), 32'd4);
    for (int i = 0; i < 4 && i < dn_cyc.size(); i++) begin
      check($sformatf("t2_done_cycle_%0d", i), dn_cyc[i], exp_cyc[i]);
      check($sformatf("t2_done_data_%0d", i), {24'd0, dn_dat[i]}, {24'd0, exp_dat[i]});
    end
    wait_idle("t2_idle");

    // 3. silent responder: each word times out after 16 cycles of send
    rmode = R_SILENT;
    for (int k = 0; k < 36; k++) begin
      if (k == 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h66;
      end else if (k == 1) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h77;
      end else begin
        bus.wr_valid = 1'b0;
      end
      step();
      es = ((k >= 1) && (k <= 16)) || ((k >= 18) && (k <= 33));
      check($sformatf("t3_send_%0d", k), {31'd0, bus.send}, {31'd0, es});
      check($sformatf("t3_terr_%0d", k), {31'd0, bus.timeout_err},
            {31'd0, (k == 17) || (k == 34)});
      check($sformatf("t3_done_%0d", k), {31'd0, bus.done}, 32'd0);
      if (k >= 1) begin
        ed = (k <= 17) ? 8'h66 : 8'h77;
        check($sformatf("t3_dout_%0d", k), {24'd0, bus.data_out}, {24'd0, ed});
      end
      check($sformatf("t3_busy_%0d", k), {31'd0, bus.busy}, {31'd0, k <= 34});
    end
    rmode = R_NORMAL;
    wait_idle("t3_idle");

    // 4. stale ack high before the push holds off the request
    rmode  = R_FORCE;
    rforce = 1'b1;
    step();
    step();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h5A;
    step();
    bus.wr_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      check($sformatf("t4_hold_send_%0d", j), {31'd0, bus.send}, 32'd0);
      check($sformatf("t4_hold_busy_%0d", j), {31'd0, bus.busy}, 32'd1);
      step();
    end
    rmode = R_NORMAL;
    got   = 1'b0;
    dv    = 8'h00;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (bus.done) begin
        got = 1'b1;
        dv  = bus.data_out;
      end
    end
    check("t4_done_seen", {31'd0, got}, 32'd1);
    check("t4_done_data", {24'd0, dv}, 32'h5A);
    wait_idle("t4_idle");

    // 5. reset while in REQ with more words queued
    rmode = R_SILENT;
    for (int k = 0; k < 4; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(8'hC0 + k);
      step();
    end
    bus.wr_valid = 1'b0;
    check("t5_in_req_send", {31'd0, bus.send}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_send",     {31'd0, bus.send},        32'd0);
    check("t5_wr_ready", {31'd0, bus.wr_ready},    32'd1);
    check("t5_busy",     {31'd0, bus.busy},        32'd0);
    check("t5_done",     {31'd0, bus.done},        32'd0);
    check("t5_terr",     {31'd0, bus.timeout_err}, 32'd0);
    check("t5_data_out", {24'd0, bus.data_out},    32'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      check($sformatf("t5_after_send_%0d", j), {31'd0, bus.send}, 32'd0);
      check($sformatf("t5_after_busy_%0d", j), {31'd0, bus.busy}, 32'd0);
    end
    rmode = R_NORMAL;

    // 6. responder keeps ack high 10 cycles after send drops
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h3C;
    step();
    bus.wr_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      step();
      if (bus.done) got = 1'b1;
    end
    check("t6_first_done", {31'd0, got}, 32'd1);
    rmode        = R_FORCE;
    rforce       = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h99;
    step();
    bus.wr_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      check($sformatf("t6_hold_send_%0d", j), {31'd0, bus.send}, 32'd0);
      check($sformatf("t6_hold_busy_%0d", j), {31'd0, bus.busy}, 32'd1);
      step();
    end
    rmode = R_NORMAL;
    got   = 1'b0;
    dv    = 8'h00;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (bus.done) begin
        got = 1'b1;
        dv  = bus.data_out;
      end
    end
    check("t6_second_done", {31'd0, got}, 32'd1);
    check("t6_second_data", {24'd0, dv}, 32'h99);
    wait_idle("t6_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
